// File: rtl/sce_fetch_rsp_if.sv
// SCE fetch handshake bus: request channel from initiator, response channel back.
// The initiator drives the master modport; the responder uses the slave modport.
interface sce_fetch_rsp_if #(
    parameter int unsigned CMDW = 32
);
    logic            REQ_VLD;
    logic            REQ_ACK;
    logic [CMDW-1:0] REQ_INFO;
    logic            RSP_VLD;
    logic            RSP_ACK;
    logic [CMDW-1:0] RSP_INFO;

    modport master (
        output REQ_VLD, REQ_INFO, RSP_ACK,
        input  REQ_ACK, RSP_VLD, RSP_INFO
    );

    modport slave (
        input  REQ_VLD, REQ_INFO, RSP_ACK,
        output REQ_ACK, RSP_VLD, RSP_INFO
    );
endinterface

// File: rtl/sce_fetch_rsp.sv
// SCE fetch responder: command memory with load port plus an in-order response FIFO.
// Define SCE_FETCH_ERR_EN to flag requests with nonzero upper index bits (ERR port).
module sce_fetch_rsp #(
    parameter int unsigned CMDW = 32,
    parameter int unsigned AW   = 4,
    parameter int unsigned RQD  = 2
) (
    input  logic            CLK,
    input  logic            RSTN,
    sce_fetch_rsp_if.slave  fif,
    input  logic            LD_VLD,
    input  logic [AW-1:0]   LD_ADDR,
`ifdef SCE_FETCH_ERR_EN
    input  logic [CMDW-1:0] LD_DATA,
    output logic            ERR
`else
    input  logic [CMDW-1:0] LD_DATA
`endif
);
    localparam int unsigned CW = $clog2(RQD + 1);
    localparam int unsigned PW = $clog2(RQD);

    logic [CMDW-1:0] mem  [2**AW];
    logic [CMDW-1:0] fifo [RQD];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            ack_q;
    logic            push, pop;
    logic [AW-1:0]   idx;
    logic [CMDW-1:0] push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RQD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign idx  = fif.REQ_INFO[AW-1:0];
    assign push = fif.REQ_VLD && ack_q;
    assign pop  = (cnt != '0) && fif.RSP_ACK;

`ifdef SCE_FETCH_ERR_EN
    logic bad_idx;
    assign bad_idx   = |fif.REQ_INFO[CMDW-1:AW];
    assign push_data = bad_idx ? '1 : mem[idx];
`else
    logic unused_hi;
    assign unused_hi = ^fif.REQ_INFO[CMDW-1:AW];
    assign push_data = mem[idx];
`endif

    assign fif.REQ_ACK  = ack_q;
    assign fif.RSP_VLD  = (cnt != '0);
    assign fif.RSP_INFO = (cnt != '0) ? fifo[rptr] : '0;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Accept is registered from next occupancy so REQ_ACK never depends on
    // REQ_VLD/RSP_ACK combinationally; a pop while full frees a slot one cycle later.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ack_q <= 1'b0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            cnt   <= cnt_nxt;
            ack_q <= (cnt_nxt < CW'(RQD));
        end
    end

`ifdef SCE_FETCH_ERR_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)               ERR <= 1'b0;
        else if (push && bad_idx) ERR <= 1'b1;
    end
`endif

    // Memory survives reset; a same-edge load and read yields the old word.
    always_ff @(posedge CLK) begin
        if (LD_VLD) mem[LD_ADDR] <= LD_DATA;
        if (push)   fifo[wptr]   <= push_data;
    end
endmodule

// File: tb/tb_sce_fetch_rsp.sv
// Scoreboard bench for sce_fetch_rsp: directed requests push expected words,
// a negedge monitor pops and compares every response transfer.
module tb_sce_fetch_rsp;
    localparam int unsigned CMDW = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned RQD  = 2;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic            LD_VLD = 1'b0;
    logic [AW-1:0]   LD_ADDR = '0;
    logic [CMDW-1:0] LD_DATA = '0;
`ifdef SCE_FETCH_ERR_EN
    logic            ERR;
`endif

    int total = 0;
    int bad   = 0;
    logic [CMDW-1:0] sb [$];
    bit stalled;

    sce_fetch_rsp_if #(.CMDW(CMDW)) bus ();

    sce_fetch_rsp #(.CMDW(CMDW), .AW(AW), .RQD(RQD)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .fif     (bus.slave),
        .LD_VLD  (LD_VLD),
        .LD_ADDR (LD_ADDR),
`ifdef SCE_FETCH_ERR_EN
        .LD_DATA (LD_DATA),
        .ERR     (ERR)
`else
        .LD_DATA (LD_DATA)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [CMDW-1:0] act, input logic [CMDW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [CMDW-1:0] d);
        LD_VLD = 1'b1; LD_ADDR = a; LD_DATA = d;
        @(posedge CLK); #1;
        LD_VLD = 1'b0;
    endtask

    // Holds REQ_VLD until accepted; returns 1 time unit after the accepting edge.
    task automatic req(input logic [CMDW-1:0] info, input logic [CMDW-1:0] exp);
        int n = 0;
        bus.REQ_VLD = 1'b1; bus.REQ_INFO = info;
        forever begin
            @(negedge CLK);
            if (bus.REQ_ACK) break;
            stalled = 1'b1;
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL req_timeout: got no accept for %h expected accept", info);
                return;
            end
        end
        sb.push_back(exp);
        @(posedge CLK); #1;
    endtask

    // Monitor: compares data on transfer, checks hold stability while stalled.
    initial begin
        logic [CMDW-1:0] held = '0;
        bit hold = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                hold = 1'b0;
            end else if (bus.RSP_VLD && bus.RSP_ACK) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got %h expected none", bus.RSP_INFO);
                end else begin
                    check("rsp_data", bus.RSP_INFO, sb.pop_front());
                end
                hold = 1'b0;
            end else if (bus.RSP_VLD) begin
                if (hold) check("rsp_hold", bus.RSP_INFO, held);
                held = bus.RSP_INFO;
                hold = 1'b1;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        if (RQD < 2) $fatal(1, "RQD must be at least 2");
        bus.REQ_VLD = 1'b0; bus.REQ_INFO = '0; bus.RSP_ACK = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_req_ack", {31'b0, bus.REQ_ACK}, 32'd0);
        check("rst_rsp_vld", {31'b0, bus.RSP_VLD}, 32'd0);
        check("rst_rsp_info", bus.RSP_INFO, 32'd0);
        @(posedge CLK); #1; RSTN = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("ack_after_rst", {31'b0, bus.REQ_ACK}, 32'd1);
`ifdef SCE_FETCH_ERR_EN
        check("err_rst", {31'b0, ERR}, 32'd0);
`endif
        @(posedge CLK); #1;

        // Single request, latency 1
        bus.RSP_ACK = 1'b1;
        ld(4'd3, 32'hDEAD_0003);
        req(32'd3, 32'hDEAD_0003);
        bus.REQ_VLD = 1'b0;
        @(negedge CLK);
        check("lat1_vld", {31'b0, bus.RSP_VLD}, 32'd1);
        @(posedge CLK); #1;

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) ld(AW'(i), CMDW'(32'h10 + i));
        stalled = 1'b0;
        for (int i = 0; i < 4; i++) req(CMDW'(i), CMDW'(32'h10 + i));
        bus.REQ_VLD = 1'b0;
        check("b2b_no_stall", {31'b0, stalled}, 32'd0);
        repeat (3) @(posedge CLK); #1;

        // Backpressure: fill, then release one slot
        ld(4'd8, 32'h88); ld(4'd9, 32'h99); ld(4'd10, 32'hAA);
        bus.RSP_ACK = 1'b0;
        req(32'd8, 32'h88);
        req(32'd9, 32'h99);
        bus.REQ_INFO = 32'd10;
        @(negedge CLK);
        check("full_ack0", {31'b0, bus.REQ_ACK}, 32'd0);
        check("full_head", bus.RSP_INFO, 32'h88);
        @(posedge CLK); #1;
        bus.RSP_ACK = 1'b1;
        @(negedge CLK);
        check("pop_same_cycle_ack0", {31'b0, bus.REQ_ACK}, 32'd0);
        @(posedge CLK); #1;
        bus.RSP_ACK = 1'b0;
        @(negedge CLK);
        check("ack_next_cycle", {31'b0, bus.REQ_ACK}, 32'd1);
        sb.push_back(32'hAA);
        @(posedge CLK); #1;
        bus.REQ_VLD = 1'b0;
        repeat (2) @(posedge CLK); #1;
        bus.RSP_ACK = 1'b1;
        repeat (3) @(posedge CLK); #1;

        // Read-before-write on the same index
        ld(4'd5, 32'hAAAA);
        LD_VLD = 1'b1; LD_ADDR = 4'd5; LD_DATA = 32'hBBBB;
        req(32'd5, 32'hAAAA);
        LD_VLD = 1'b0;
        req(32'd5, 32'hBBBB);
        bus.REQ_VLD = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // Reset mid-stream discards buffered responses, memory survives
        ld(4'd7, 32'h77);
        bus.RSP_ACK = 1'b0;
        req(32'd1, 32'h11);
        req(32'd2, 32'h12);
        bus.REQ_VLD = 1'b0;
        RSTN = 1'b0;
        sb.delete();
        @(negedge CLK);
        check("midrst_vld", {31'b0, bus.RSP_VLD}, 32'd0);
        check("midrst_info", bus.RSP_INFO, 32'd0);
        check("midrst_ack", {31'b0, bus.REQ_ACK}, 32'd0);
        @(posedge CLK); #1; RSTN = 1'b1;
        bus.RSP_ACK = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("post_rst_vld", {31'b0, bus.RSP_VLD}, 32'd0);
        check("post_rst_ack", {31'b0, bus.REQ_ACK}, 32'd1);
        repeat (3) @(posedge CLK); #1;
        req(32'd7, 32'h77);
        bus.REQ_VLD = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // Upper index bits
`ifdef SCE_FETCH_ERR_EN
        req(32'h0000_0013, 32'hFFFF_FFFF);
        bus.REQ_VLD = 1'b0;
        @(negedge CLK);
        check("err_set", {31'b0, ERR}, 32'd1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("err_sticky", {31'b0, ERR}, 32'd1);
        @(posedge CLK); #1;
`else
        req(32'h0000_0013, 32'h13);
        bus.REQ_VLD = 1'b0;
`endif

        // Drain
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge CLK); n++;
        end
        repeat (2) @(posedge CLK);
        check("drain_empty", CMDW'(sb.size()), 32'd0);
        @(negedge CLK);
        check("final_vld", {31'b0, bus.RSP_VLD}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sce_fetch_rsp.md
Name: sce_fetch_rsp

Overview:
- Responder end of the SCE fetch interface. Accepts fetch requests from the SCE fetch initiator and returns command words.
- Each request carries a command-memory index in REQ_INFO. The matching command word comes back on RSP_INFO.
- Commands are held in an internal command memory written through a simple load port. Accepted responses are buffered in a small in-order response FIFO.

Parameters:
- CMDW, 32, width of REQ_INFO, RSP_INFO and LD_DATA.
- AW, 4, command memory index width; memory depth is 2**AW entries.
- RQD, 2, response FIFO depth; legal range 2..16; the bench checks RQD>=2.

Ports:
- CLK  in  1  clock, all logic rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- REQ_VLD  in  1  request valid from initiator.
- REQ_ACK  out  1  responder can accept a request this cycle.
- REQ_INFO  in  CMDW  request payload; bits [AW-1:0] are the command index.
- RSP_VLD  out  1  response valid.
- RSP_ACK  in  1  initiator accepts the response this cycle.
- RSP_INFO  out  CMDW  response payload (command word).
- LD_VLD  in  1  command memory write strobe.
- LD_ADDR  in  AW  command memory write index.
- LD_DATA  in  CMDW  command memory write data.
- ERR  out  1  sticky bad-index flag; present only with SCE_FETCH_ERR_EN.

Behaviour:
- Handshakes:
  - Request transfer occurs on a rising edge where REQ_VLD && REQ_ACK.
  - Response transfer occurs on a rising edge where RSP_VLD && RSP_ACK.
  - The initiator holds REQ_VLD/REQ_INFO stable until transfer.
  - The responder holds RSP_VLD/RSP_INFO stable while RSP_VLD && !RSP_ACK.
- REQ_ACK = (cnt < RQD). It is a function of registered state only, with no combinational path from REQ_VLD or RSP_ACK.
- FIFO:
  - RQD entries, write pointer, read pointer, occupancy cnt (width clog2(RQD+1)).
  - Pointers wrap from RQD-1 to 0.
- Request accept at edge N:
  - mem[REQ_INFO[AW-1:0]] is read synchronously and written into FIFO[wptr] at edge N; wptr advances.
  - RSP_VLD is high in the cycle after edge N if the FIFO was empty, giving a latency of 1 cycle.
- RSP_VLD = (cnt != 0). RSP_INFO = FIFO[rptr] when RSP_VLD; it is driven to 0 when the FIFO is empty.
- Count update on each edge:
  - Push only: cnt+1.
  - Pop only: cnt-1.
  - Push and pop together: cnt unchanged, both pointers advance.
- Full (cnt==RQD): REQ_ACK=0. A simultaneous pop does not raise REQ_ACK in the same cycle; it rises the next cycle.
- Empty with a request accepted: the data appears at the head next cycle. There is no bypass path in the same cycle.
- Throughput: with RQD>=2 and RSP_ACK tied high, one request per cycle is sustained.
- Load port:
  - LD_VLD writes mem[LD_ADDR]<=LD_DATA at the edge.
  - A load and a request read of the same index on the same edge return the OLD data (read-before-write).
  - Loads never stall and are independent of the handshakes.
- REQ_INFO bits [CMDW-1:AW] are ignored, so the index wraps modulo 2**AW (without the feature).
- Reset values, applied asynchronously when RSTN=0:
  - REQ_ACK=0 while RSTN low; REQ_ACK=1 from the first cycle after release.
  - RSP_VLD=0, RSP_INFO=0, cnt=0, wptr=rptr=0, ERR=0.
  - Command memory contents are NOT reset; they are retained across reset.
- Reset mid-operation: all buffered responses are discarded. No response for a pre-reset request is ever issued after reset.

Optional Feature:
- Macro: SCE_FETCH_ERR_EN.
- With the macro:
  - A request whose REQ_INFO[CMDW-1:AW] != 0 is still accepted and still occupies a FIFO slot.
  - Its response has RSP_INFO = all ones, and the memory is not read.
  - ERR is set at the accepting edge and stays high until reset.
- Without the macro:
  - The ERR port does not exist.
  - Upper bits are ignored and the index wraps as described above.

Test Plan:
- Load mem[3]=32'hDEAD_0003; request REQ_INFO=3 with RSP_ACK=1 -> RSP_VLD high 1 cycle after accept, RSP_INFO=32'hDEAD_0003.
- Load mem[0..3]=0x10..0x13; hold REQ_VLD for indexes 0,1,2,3 back-to-back with RSP_ACK=1 -> 4 responses on consecutive cycles, in order 0x10..0x13, REQ_ACK never low.
- RQD=2, RSP_ACK=0; issue 3 requests -> REQ_ACK drops after 2 accepts, RSP_INFO held stable. Raise RSP_ACK for one cycle -> REQ_ACK returns next cycle, third response emerges after the second, in order.
- LD_VLD to index 5 with 0xBBBB on the same edge as accepting a request for index 5 (old value 0xAAAA) -> response 0xAAAA; the next request to 5 returns 0xBBBB.
- Fill the FIFO, assert RSTN=0 mid-stream, release -> RSP_VLD=0, cnt=0, no stale responses. A request to a preloaded index returns the preloaded value (memory retained).
- Request REQ_INFO=32'h0000_0013 (AW=4):
  - Without SCE_FETCH_ERR_EN -> returns mem[3].
  - With SCE_FETCH_ERR_EN -> RSP_INFO=32'hFFFF_FFFF and ERR=1 until reset.
